// File: rtl/ifu_pf.sv
// ifu_pf: sequential instruction prefetcher with in-flight tracking and a DEPTH-entry queue.
// Optional feature macro IFU_PF_BYPASS_EN: forward a response to decode when the queue is empty.
module ifu_pf #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              reqValid,
    input  logic              reqReady,
    output logic [ADDR_W-1:0] reqAddr,
    input  logic              respValid,
    input  logic [INST_W-1:0] respData,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              is_busy
);
    localparam int             PTR_W  = $clog2(DEPTH);
    localparam int             CNT_W  = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [INST_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic              q_empty, resp_ok, accept, bypass, push, pop;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  out_after_resp;

    assign q_empty        = (cnt_q == '0);
    assign resp_ok        = respValid && (out_q != '0);
    assign accept         = reqValid && reqReady;
    assign out_after_resp = out_q - CNT_W'(resp_ok);
    // In-flight requests are always consecutive words, so the oldest one trails fetch_pc.
    assign resp_pc        = fetch_pc_q - (ADDR_W'(out_q) << 2);

`ifdef IFU_PF_BYPASS_EN
    assign bypass = (state_q == FETCH) && q_empty && resp_ok && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !redirect_valid && !q_empty && inst_ready;
    assign push = !redirect_valid && (state_q == FETCH) && resp_ok && !(bypass && inst_ready);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!redirect_valid && fetch_en) state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid)                 state_d = (out_after_resp != '0) ? FLUSH : FETCH;
                else if (!fetch_en && out_q == '0) state_d = IDLE;
            end
            FLUSH: begin
                if (!redirect_valid && out_after_resp == '0) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reqValid   = (state_q == FETCH) && fetch_en && !redirect_valid &&
                     (({1'b0, out_q} + {1'b0, cnt_q}) < CREDIT);
        inst_valid = !q_empty || bypass;
        inst_data  = '0;
        inst_pc    = '0;
        if (!q_empty) begin
            inst_data = data_mem[rd_ptr_q];
            inst_pc   = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            inst_data = respData;
            inst_pc   = resp_pc;
        end
    end

    assign reqAddr = fetch_pc_q;
    assign is_busy = (state_q != IDLE) || (out_q != '0) || !q_empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid)  fetch_pc_d = redirect_pc;
        else if (accept)     fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        case ({accept, resp_ok})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
        if (redirect_valid) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage is never reset; an empty queue masks it at the outputs.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q] <= respData;
            pc_mem[wr_ptr_q]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_ifu_pf.sv
// tb_ifu_pf: directed stimulus queues expected requests/instructions; a falling-edge monitor
// compares them against what ifu_pf presents. Memory returns ~address as instruction data.
`timescale 1ns/1ps
module tb_ifu_pf;
    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        respValid;
    logic [31:0] respData;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        is_busy;

`ifdef IFU_PF_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] pend_q[$];
    int          acc_cnt   = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    bit          resp_hold = 1'b0;
    int          base;

    ifu_pf dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .respValid(respValid), .respData(respData),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .is_busy(is_busy)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endfunction

    function automatic void fail_now(string name, logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected nothing at %0t", name, act, $time);
    endfunction

    // Monitor: scoreboards requests and instructions on the falling edge.
    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset && reqValid && reqReady) begin
            acc_cnt++;
            pend_q.push_back(reqAddr);
            if (exp_req_q.size() == 0) fail_now("req_unexpected", reqAddr);
            else begin
                e = exp_req_q.pop_front();
                chk("reqAddr", reqAddr, e);
            end
        end
        if (!reset && inst_valid && inst_ready) begin
            if (exp_inst_q.size() == 0) fail_now("inst_unexpected", inst_pc);
            else begin
                e = exp_inst_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst_data", inst_data, ~e);
            end
        end
        if (respValid && pend_q.size() == 0) fail_now("resp_without_request", respData);
    end

    // Memory model: answers accepted requests in order, one cycle after acceptance.
    initial begin
        logic [31:0] drop;
        respValid = 1'b0;
        respData  = '0;
        forever begin
            @(posedge clock);
            #2;
            if (respValid) drop = pend_q.pop_front();
            if (!resp_hold && pend_q.size() != 0) begin
                respValid = 1'b1;
                respData  = ~pend_q[0];
            end else begin
                respValid = 1'b0;
                respData  = '0;
            end
        end
    end

    task automatic wait_acc(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            if (acc_cnt >= target) begin
                hit = 1'b1;
                break;
            end
        end
        #1;
        chk1("accept_count_reached", hit, 1'b1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!is_busy && exp_inst_q.size() == 0 && exp_req_q.size() == 0 && pend_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk1("drain_to_idle", done, 1'b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        reqReady = 1'b0; inst_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk1("rst_reqValid", reqValid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_is_busy", is_busy, 1'b0);
        chk("rst_reqAddr", reqAddr, 32'h8000_0000);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        @(posedge clock); #1;

        // Streaming fetch: one request and one instruction per cycle.
        foreach (exp_req_q[i]) ;
        for (int i = 0; i < 6; i++) begin
            exp_req_q.push_back(32'h8000_0000 + 32'(4 * i));
            exp_inst_q.push_back(32'h8000_0000 + 32'(4 * i));
        end
        fetch_en = 1'b1; reqReady = 1'b1; inst_ready = 1'b1;
        base = acc_cnt;
        wait_acc(base + 6);
        fetch_en = 1'b0;
        wait_idle();

        // Stalled decode: credit limit stops issue at DEPTH.
        for (int i = 0; i < 5; i++) begin
            exp_req_q.push_back(32'h8000_0018 + 32'(4 * i));
            exp_inst_q.push_back(32'h8000_0018 + 32'(4 * i));
        end
        base = acc_cnt;
        inst_ready = 1'b0; fetch_en = 1'b1;
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("credit_accepts", 32'(acc_cnt - base), 32'd4);
        chk1("credit_reqValid_low", reqValid, 1'b0);
        @(posedge clock); #1 inst_ready = 1'b1;
        @(posedge clock); #1 inst_ready = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        chk("credit_one_more", 32'(acc_cnt - base), 32'd5);
        @(posedge clock); #1;
        fetch_en = 1'b0; inst_ready = 1'b1;
        wait_idle();

        // Back-pressure on the request port holds the address.
        exp_req_q.push_back(32'h8000_002C); exp_req_q.push_back(32'h8000_0030);
        exp_inst_q.push_back(32'h8000_002C); exp_inst_q.push_back(32'h8000_0030);
        base = acc_cnt;
        reqReady = 1'b0; fetch_en = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_reqAddr", reqAddr, 32'h8000_002C);
            chk1("stall_reqValid", reqValid, 1'b1);
        end
        chk("stall_no_accept", 32'(acc_cnt - base), 32'd0);
        @(posedge clock); #1 reqReady = 1'b1;
        wait_acc(base + 2);
        fetch_en = 1'b0;
        wait_idle();

        // Redirect with two requests in flight: flush, then restart at 0x100.
        exp_req_q.push_back(32'h8000_0034); exp_req_q.push_back(32'h8000_0038);
        exp_req_q.push_back(32'h0000_0100); exp_req_q.push_back(32'h0000_0104);
        exp_inst_q.push_back(32'h0000_0100); exp_inst_q.push_back(32'h0000_0104);
        base = acc_cnt;
        resp_hold = 1'b1; fetch_en = 1'b1;
        wait_acc(base + 2);
        reqReady = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(posedge clock); #1;
        redirect_valid = 1'b0; reqReady = 1'b1; resp_hold = 1'b0;
        @(negedge clock);
        chk1("flush_reqValid", reqValid, 1'b0);
        chk1("flush_inst_valid", inst_valid, 1'b0);
        chk("flush_reqAddr", reqAddr, 32'h0000_0100);
        wait_acc(base + 4);
        fetch_en = 1'b0;
        wait_idle();

        // Redirect in IDLE, then address wrap past the top of memory.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clock); #1 redirect_valid = 1'b0;
        @(negedge clock);
        chk("idle_redirect_reqAddr", reqAddr, 32'hFFFF_FFFC);
        chk1("idle_redirect_busy", is_busy, 1'b0);
        exp_req_q.push_back(32'hFFFF_FFFC); exp_req_q.push_back(32'h0000_0000);
        exp_inst_q.push_back(32'hFFFF_FFFC); exp_inst_q.push_back(32'h0000_0000);
        @(posedge clock); #1;
        base = acc_cnt;
        fetch_en = 1'b1;
        wait_acc(base + 2);
        fetch_en = 1'b0;
        wait_idle();

        // Response into an empty queue: decode latency.
        exp_req_q.push_back(32'h0000_0004);
        exp_inst_q.push_back(32'h0000_0004);
        base = acc_cnt;
        fetch_en = 1'b1;
        wait_acc(base + 1);
        fetch_en = 1'b0;
        @(negedge clock);
        chk1("empty_resp_same_cycle", inst_valid, BYP);
        @(negedge clock);
        chk1("empty_resp_next_cycle", inst_valid, ~BYP);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
